rush_hour_report: RTL
=====================

# rush_hour_report

Per-day history buffer and playback sequencer for the rush-hour detector. It sits downstream of the rush-hour datapath and the hour counter. At each work-day end it stores the day's rush start/end record, then on request replays the stored days oldest-first on the display outputs, holding each entry for a fixed dwell time.

## Interface
- `DAYS`, default 4: history depth in days; power of two, minimum 2.
- `DWELL`, default 50_000_000: clock cycles each entry is held on the display; minimum 1.
- `clk` input, 1 bit: system clock, rising edge.
- `reset` input, 1 bit: asynchronous, active-low reset.
- `day_end` input, 1 bit: one-cycle pulse at work-day expiry; triggers a record write.
- `rush_start` input, 4 bits: first rush-start hour of the current day.
- `rush_start_exist` input, 1 bit: rush start recorded today.
- `rush_end` input, 4 bits: first rush-end hour of the current day.
- `rush_end_exist` input, 1 bit: rush end recorded today.
- `show` input, 1 bit: level request to play back the history.
- `busy` output, 1 bit: playback in progress (states LOAD, HOLD).
- `day_count` output, clog2(DAYS)+1 bits: number of stored days, saturating at DAYS.
- `disp_day` output, clog2(DAYS) bits: age of the displayed entry; 0 = oldest.
- `disp_start` output, 4 bits: displayed rush-start hour.
- `disp_start_valid` output, 1 bit: displayed entry has a rush start.
- `disp_end` output, 4 bits: displayed rush-end hour.
- `disp_end_valid` output, 1 bit: displayed entry has a rush end.

## Operation
- Record format: 10 bits, {start_exist, start, end_exist, end}.
- Storage: circular buffer of DAYS records, write pointer `wr_ptr`.
- Write side:
  - On `day_end`=1, store the record at `wr_ptr`, then increment `wr_ptr` modulo DAYS.
  - `day_count` increments by 1 and saturates at DAYS.
  - When the buffer is full, the write overwrites the oldest record.
  - Oldest index is `wr_ptr - day_count` modulo DAYS.
- Read FSM:
  - States: IDLE, LOAD, HOLD, DONE.
  - IDLE: when `show`=1 and `day_count`>0, snapshot `n`=`day_count` and `rd_ptr`=oldest index, clear `idx`, go to LOAD. When `show`=1 and `day_count`=0, stay in IDLE.
  - LOAD: register `mem[rd_ptr]` onto the disp outputs, set `disp_day`=`idx`, load the dwell counter with DWELL-1, go to HOLD.
  - HOLD: decrement the dwell counter. At 0: if `idx`=`n`-1, go to DONE; otherwise increment `idx` and `rd_ptr` (modulo DAYS) and go to LOAD.
  - DONE: disp outputs keep the last entry. Go to IDLE when `show`=0.
- `show` deasserted in LOAD or HOLD: playback continues to completion. No abort.
- `day_end` during playback: the write is always accepted. Playback order and length come from the snapshot. A slot overwritten before it is loaded displays the new content.
- `day_end` in the same cycle as the IDLE→LOAD transition: the snapshot uses the pre-write `day_count` and `wr_ptr`.

## Timing
- Reset values: FSM IDLE; `wr_ptr`, `day_count`, `busy`, `disp_day`, `disp_start`, `disp_start_valid`, `disp_end`, `disp_end_valid` all 0. Buffer contents are don't-care.
- All outputs are registered.
- The record written on `day_end` at edge k is readable from edge k+1.
- `show` sampled high at edge k: LOAD at k+1; disp outputs valid after edge k+2.
- Each entry is displayed for DWELL+1 cycles (LOAD plus DWELL HOLD cycles).
- A full playback of `n` entries occupies `n`×(DWELL+1) cycles, then the FSM enters DONE.
- `busy` is high from edge k+1 until DONE is entered.
- `reset` asserted mid-playback: immediate return to reset values. The history is lost (`day_count`=0).

## Configuration
- `RUSH_REPORT_LOOP_EN` defined: at the end of the last HOLD, if `show`=1, reload `idx`=0 and `rd_ptr`=oldest with a fresh snapshot and go to LOAD. Playback repeats until `show`=0 at a wrap point, then goes to IDLE. The DONE state is not used.
- `RUSH_REPORT_LOOP_EN` undefined: single-pass playback as described under Operation.

## Test plan
- Reset, then `show`=1 with no days stored -> FSM stays IDLE, `busy`=0, all disp outputs 0.
- DAYS=4, DWELL=3; write days (9,1,13,1), (10,1,0,0); pulse `show` -> disp shows 9/1/13/1 with `disp_day`=0 for 4 cycles, then 10/1/0/0 with `disp_day`=1 for 4 cycles, then DONE.
- Write 6 days, hours 1..6 as start -> `day_count`=4; playback shows starts 3,4,5,6 in that order.
- `day_end` pulsed while entry 0 is in HOLD with `n`=2 and buffer not full -> playback still shows exactly 2 entries, `day_count` becomes 3.
- Assert `reset` during HOLD -> next cycle `busy`=0, `day_count`=0, disp outputs 0; a following `show` produces no playback.
- With `RUSH_REPORT_LOOP_EN`, 2 days stored, `show` held high -> entries repeat in the order 0,1,0,1; dropping `show` mid-entry ends playback after entry 1, then the FSM returns to IDLE.

Source files
------------

// File: rtl/rush_hour_report.sv
// Per-day rush-hour history buffer with oldest-first playback sequencer.
// Define RUSH_REPORT_LOOP_EN to repeat playback while show stays high.
module rush_hour_report #(
  parameter int unsigned DAYS  = 4,
  parameter int unsigned DWELL = 50_000_000
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_day_end,
  input  logic [3:0]             i_rush_start,
  input  logic                   i_rush_start_exist,
  input  logic [3:0]             i_rush_end,
  input  logic                   i_rush_end_exist,
  input  logic                   i_show,
  output logic                   o_busy,
  output logic [$clog2(DAYS):0]  o_day_count,
  output logic [$clog2(DAYS)-1:0] o_disp_day,
  output logic [3:0]             o_disp_start,
  output logic                   o_disp_start_valid,
  output logic [3:0]             o_disp_end,
  output logic                   o_disp_end_valid
);

  localparam int unsigned AW = $clog2(DAYS);
  localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic [1:0] {StIdle, StLoad, StHold, StDone} state_e;

  state_e          r_state, w_state_d;
  logic [9:0]      r_mem [DAYS];
  logic [AW-1:0]   r_wr_ptr, r_rd_ptr, r_idx, w_oldest;
  logic [AW:0]     r_day_count, r_n;
  logic [CW-1:0]   r_dwell;
  logic [9:0]      r_disp;
  logic [AW-1:0]   r_disp_day;
  logic            r_busy;
  logic [9:0]      w_rec;
  logic            w_snap, w_load, w_adv, w_last, w_dwell_zero;

  assign w_rec        = {i_rush_start_exist, i_rush_start, i_rush_end_exist, i_rush_end};
  assign w_oldest     = r_wr_ptr - r_day_count[AW-1:0];
  assign w_last       = ({1'b0, r_idx} == (r_n - (AW+1)'(1)));
  assign w_dwell_zero = (r_dwell == '0);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: if (i_show && (r_day_count != '0)) w_state_d = StLoad;
      StLoad: w_state_d = StHold;
      StHold: begin
        if (w_dwell_zero) begin
          if (!w_last) begin
            w_state_d = StLoad;
          end else begin
`ifdef RUSH_REPORT_LOOP_EN
            w_state_d = i_show ? StLoad : StIdle;
`else
            w_state_d = StDone;
`endif
          end
        end
      end
      StDone: if (!i_show) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // A snapshot is taken both on a fresh start and on a loop wrap.
  always_comb begin
    w_snap = 1'b0;
    w_load = 1'b0;
    w_adv  = 1'b0;
    unique case (r_state)
      StIdle: w_snap = (w_state_d == StLoad);
      StLoad: w_load = 1'b1;
      StHold: begin
        if (w_dwell_zero && (w_state_d == StLoad)) begin
          if (w_last) w_snap = 1'b1;
          else        w_adv  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_day_end) r_mem[r_wr_ptr] <= w_rec;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_wr_ptr    <= '0;
      r_day_count <= '0;
      r_n         <= '0;
      r_rd_ptr    <= '0;
      r_idx       <= '0;
      r_dwell     <= '0;
      r_disp      <= '0;
      r_disp_day  <= '0;
      r_busy      <= 1'b0;
    end else begin
      if (i_day_end) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
        if (r_day_count != (AW+1)'(DAYS)) r_day_count <= r_day_count + (AW+1)'(1);
      end
      if (w_snap) begin
        r_n      <= r_day_count;
        r_rd_ptr <= w_oldest;
        r_idx    <= '0;
      end else if (w_adv) begin
        r_idx    <= r_idx + AW'(1);
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_load) begin
        r_disp     <= r_mem[r_rd_ptr];
        r_disp_day <= r_idx;
        r_dwell    <= CW'(DWELL - 1);
      end else if ((r_state == StHold) && !w_dwell_zero) begin
        r_dwell <= r_dwell - CW'(1);
      end
      r_busy <= (w_state_d == StLoad) || (w_state_d == StHold);
    end
  end

  assign o_busy             = r_busy;
  assign o_day_count        = r_day_count;
  assign o_disp_day         = r_disp_day;
  assign o_disp_start_valid = r_disp[9];
  assign o_disp_start       = r_disp[8:5];
  assign o_disp_end_valid   = r_disp[4];
  assign o_disp_end         = r_disp[3:0];

endmodule
